// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for an MCP4921-style 12-bit DAC: one 16-bit write
// frame per accepted sample, followed by an LDAC strobe and a short gap.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 25,
    parameter bit          BUF     = 1'b0,
    parameter bit          GAIN_1X = 1'b1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [11:0] data,
    input  logic        valid,
    output logic        ready,
    output logic        done,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);
    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HMAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LDAC, GAP} state_t;

    state_t        state;
    logic [CW-1:0] hcnt;
    logic [3:0]    bcnt;
    logic [14:0]   shreg;
    logic [15:0]   frame;
    logic          wrap;

    assign frame = {1'b0, BUF, GAIN_1X, 1'b1, data};
    assign wrap  = (hcnt == HMAX);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            hcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // ready is high throughout IDLE, so valid alone marks an accept
                    if (valid) begin
                        state    <= SHIFT;
                        ready    <= 1'b0;
                        hcnt     <= '0;
                        bcnt     <= '0;
                        shreg    <= frame[14:0];
                        dac_cs_n <= 1'b0;
                        dac_sclk <= 1'b0;
                        dac_mosi <= frame[15];
                    end
                end
                SHIFT: begin
                    hcnt <= wrap ? '0 : hcnt + 1'b1;
                    if (wrap) begin
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else if (bcnt == 4'd15) begin
                            // last falling edge closes the frame and opens LDAC
                            state      <= LDAC;
                            bcnt       <= '0;
                            dac_cs_n   <= 1'b1;
                            dac_sclk   <= 1'b0;
                            dac_mosi   <= 1'b0;
                            dac_ldac_n <= 1'b0;
                        end else begin
                            bcnt     <= bcnt + 4'd1;
                            dac_sclk <= 1'b0;
                            dac_mosi <= shreg[14];
                            shreg    <= {shreg[13:0], 1'b0};
                        end
                    end
                end
                LDAC: begin
                    hcnt <= wrap ? '0 : hcnt + 1'b1;
                    if (wrap) begin
                        state      <= GAP;
                        dac_ldac_n <= 1'b1;
                    end
                end
                GAP: begin
                    hcnt <= wrap ? '0 : hcnt + 1'b1;
                    if (wrap) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (H=25, H=1, H=2 with BUF=1/GAIN_1X=0)
// checked every cycle against a frame-timeline model plus an SPI capture.
module tb_dac_spi_tx;
    localparam int N = 3;

    logic                clk = 1'b0;
    logic                nreset;
    logic [N-1:0]        valid_v;
    logic [N-1:0][11:0]  data_v;
    wire  [N-1:0]        ready_v, done_v, cs_v, sclk_v, mosi_v, ldac_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(25)) u_dut0 (
        .clk(clk), .nreset(nreset), .data(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .done(done_v[0]), .dac_cs_n(cs_v[0]),
        .dac_sclk(sclk_v[0]), .dac_mosi(mosi_v[0]), .dac_ldac_n(ldac_v[0]));
    dac_spi_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .nreset(nreset), .data(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .done(done_v[1]), .dac_cs_n(cs_v[1]),
        .dac_sclk(sclk_v[1]), .dac_mosi(mosi_v[1]), .dac_ldac_n(ldac_v[1]));
    dac_spi_tx #(.CLK_DIV(2), .BUF(1'b1), .GAIN_1X(1'b0)) u_dut2 (
        .clk(clk), .nreset(nreset), .data(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .done(done_v[2]), .dac_cs_n(cs_v[2]),
        .dac_sclk(sclk_v[2]), .dac_mosi(mosi_v[2]), .dac_ldac_n(ldac_v[2]));

    function automatic int h_of(input int i);
        return (i == 0) ? 25 : ((i == 1) ? 1 : 2);
    endfunction

    function automatic logic [15:0] mk_frame(input int i, input logic [11:0] d);
        return {1'b0, (i == 2), (i != 2), 1'b1, d};
    endfunction

    // {ready, done, cs_n, sclk, mosi, ldac_n}; t = clk edges since accept, -1 = idle
    function automatic logic [5:0] exp_out(input int h, input int t, input logic [15:0] f);
        if (t < 0)      return 6'b101001;
        if (t == 34*h)  return 6'b111001;
        if (t < 32*h)   return {3'b000, 1'(((t / h) % 2)), f[15 - t / (2*h)], 1'b1};
        if (t < 33*h)   return 6'b001000;
        return 6'b001001;
    endfunction

    function automatic logic [5:0] outs(input int i);
        return {ready_v[i], done_v[i], cs_v[i], sclk_v[i], mosi_v[i], ldac_v[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // behavioural model: frame timeline per instance
    int          t_m[N]   = '{-1, -1, -1};
    logic [15:0] f_m[N];
    int          n_acc[N] = '{0, 0, 0};

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) t_m[i] = -1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (t_m[i] < 0 || t_m[i] == 34 * h_of(i)) begin
                    if (valid_v[i]) begin
                        t_m[i] = 0;
                        f_m[i] = mk_frame(i, data_v[i]);
                        n_acc[i]++;
                    end else begin
                        t_m[i] = -1;
                    end
                end else begin
                    t_m[i]++;
                end
            end
        end
    end

    // compare process plus SPI slave sampling on rising sclk
    logic [15:0] sh_s[N], last_f[N], prev_f[N];
    int          nb_s[N]    = '{0, 0, 0};
    int          nframes[N] = '{0, 0, 0};
    logic [N-1:0] cs_p = '1, sclk_p = '0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("cycle outputs dut%0d t=%0d", i, t_m[i]),
                32'(outs(i)), 32'(exp_out(h_of(i), t_m[i], f_m[i])));
            if (!cs_v[i]) begin
                if (cs_p[i]) begin
                    sh_s[i] = '0;
                    nb_s[i] = 0;
                end
                if (sclk_v[i] && !sclk_p[i]) begin
                    sh_s[i] = {sh_s[i][14:0], mosi_v[i]};
                    nb_s[i]++;
                end
            end else if (!cs_p[i] && nreset && nb_s[i] == 16) begin
                prev_f[i] = last_f[i];
                last_f[i] = sh_s[i];
                nframes[i]++;
                chk($sformatf("spi frame dut%0d", i), 32'(sh_s[i]), 32'(f_m[i]));
            end
            cs_p[i]   = cs_v[i];
            sclk_p[i] = sclk_v[i];
        end
    end

    task automatic send(input int i, input logic [11:0] d);
        @(negedge clk);
        data_v[i]  = d;
        valid_v[i] = 1'b1;
        @(posedge clk);
        #1 valid_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int k);
        k = 0;
        for (int j = 1; j <= 2000 && k == 0; j++) begin
            @(negedge clk);
            if (done_v[i]) k = j;
        end
        if (k == 0) chk($sformatf("done timeout dut%0d", i), 0, 1);
    endtask

    int k, cs_lo, ld_lo, gap, fall2, to, seen_done, seen_ldac;
    int base[N];

    initial begin
        valid_v = '0;
        data_v  = '0;
        nreset  = 1'b1;
        #1 nreset = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("reset idle dut%0d", i), 32'(outs(i)), 32'h29);
        #2 nreset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("post-reset idle dut%0d", i), 32'(outs(i)), 32'h29);

        // single frame at H=25 with data/valid disturbed mid-frame
        send(0, 12'hABC);
        cs_lo = 0; ld_lo = 0; k = 0;
        for (int j = 1; j <= 1200 && k == 0; j++) begin
            @(negedge clk);
            if (!cs_v[0]) cs_lo++;
            if (!ldac_v[0]) ld_lo++;
            if (done_v[0]) k = j;
            if (j == 300) begin data_v[0] = 12'h555; valid_v[0] = 1'b1; end
            if (j == 310) valid_v[0] = 1'b0;
            if (j == 500) valid_v[0] = 1'b1;
            if (j == 505) valid_v[0] = 1'b0;
        end
        chk("H25 done latency", k, 851);
        chk("H25 cs low cycles", cs_lo, 800);
        chk("H25 ldac low cycles", ld_lo, 25);
        chk("H25 captured frame", 32'(last_f[0]), 32'h3ABC);
        repeat (20) @(negedge clk);
        chk("H25 frame count", nframes[0], 1);

        // back-to-back at H=1
        @(negedge clk);
        data_v[1] = 12'hFFF; valid_v[1] = 1'b1;
        @(posedge clk);
        #1 data_v[1] = 12'h000;
        gap = 0; fall2 = 0;
        for (int j = 1; j <= 100 && fall2 == 0; j++) begin
            @(negedge clk);
            if (j > 1 && cs_v[1]) gap++;
            if (j > 1 && !cs_v[1] && gap > 0) begin
                fall2 = j;
                valid_v[1] = 1'b0;
            end
        end
        chk("H1 cs high gap", gap, 3);
        chk("H1 frame period", fall2 - 1, 35);
        wait_done(1, k);
        chk("H1 second done", k, 34);
        chk("H1 first frame", 32'(prev_f[1]), 32'h3FFF);
        chk("H1 second frame", 32'(last_f[1]), 32'h3000);

        // reset after the 7th rising sclk
        send(0, 12'hABC);
        to = 0;
        while (nb_s[0] < 7 && to < 1000) begin @(negedge clk); to++; end
        if (to >= 1000) chk("wait 7th sclk rise", 0, 1);
        #2 nreset = 1'b0;
        #1 chk("async reset outputs", 32'(outs(0)), 32'h29);
        repeat (3) @(negedge clk);
        #2 nreset = 1'b1;
        seen_done = 0; seen_ldac = 0;
        repeat (900) begin
            @(negedge clk);
            if (done_v[0]) seen_done++;
            if (!ldac_v[0]) seen_ldac++;
        end
        chk("abort no done", seen_done, 0);
        chk("abort no ldac", seen_ldac, 0);
        chk("abort frame count", nframes[0], 1);
        send(0, 12'h123);
        wait_done(0, k);
        chk("post-abort done latency", k, 851);
        chk("post-abort frame", 32'(last_f[0]), 32'h3123);

        // BUF=1, GAIN_1X=0 at H=2
        send(2, 12'h800);
        wait_done(2, k);
        chk("param done latency", k, 69);
        chk("param frame", 32'(last_f[2]), 32'h5800);

        // random traffic on all instances
        for (int i = 0; i < N; i++) base[i] = n_acc[i] - nframes[i];
        repeat (4000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                valid_v[i] = ($urandom_range(0, 3) == 0);
                data_v[i]  = 12'($urandom);
            end
        end
        @(negedge clk);
        valid_v = '0;
        repeat (900) @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("random frames completed dut%0d", i), n_acc[i] - nframes[i], base[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
